// File: rtl/ebpc_pkg.sv
// Shared definitions for the EBPC stream packer: lane ids and flush FSM states.
// Latency: none, definitions only.
// Backpressure: none, definitions only.
package ebpc_pkg;

    localparam logic SRC_ZNZ = 1'b0;
    localparam logic SRC_BPC = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        DRAIN = 2'd2
    } flush_state_e;

endpackage

// File: rtl/ebpc_pack_lane.sv
// One lane of the packer: assembles DATA_W bytes little-endian into an OUT_W word.
// Latency: the byte completing a word is visible in the out register one edge later.
// Backpressure: rdy_o drops only when the word would complete while the out register stays full.
module ebpc_pack_lane
    import ebpc_pkg::*;
#(
    parameter  int DATA_W = 8,
    parameter  int OUT_W  = 32,
    localparam int N      = OUT_W / DATA_W,
    localparam int CW     = (N > 1) ? $clog2(N) : 1,
    localparam int BW     = $clog2(N) + 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [DATA_W-1:0] data_i,
    input  logic              vld_i,
    output logic              rdy_o,
    input  logic              accept_en_i,
    input  logic              fin_i,
    output logic              fin_done_o,
    input  logic              drain_i,
    output logic [OUT_W-1:0]  out_data_o,
    output logic [BW-1:0]     out_bytes_o,
    output logic              out_last_o,
    output logic              out_vld_o
);

    localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

    logic [OUT_W-1:0] asm_q, asm_d, asm_wr;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [OUT_W-1:0] out_data_q, out_data_d;
    logic [BW-1:0]    out_bytes_q, out_bytes_d;
    logic             out_last_q, out_last_d;
    logic             out_vld_q, out_vld_d;
    logic             out_free, acc, complete, fin_fire;

    // Handshake decode: the out register counts as free when it is empty or leaving this cycle.
    always_comb begin
        out_free   = !out_vld_q || drain_i;
        rdy_o      = accept_en_i && ((cnt_q != LAST_IDX) || out_free);
        acc        = vld_i && rdy_o;
        complete   = acc && (cnt_q == LAST_IDX);
        fin_fire   = fin_i && out_free;
        fin_done_o = fin_fire;
    end

    // Next state: write the byte into slice cnt, hand full or finalised words to the out register.
    always_comb begin
        asm_wr = asm_q;
        for (int i = 0; i < N; i++) begin
            if (cnt_q == CW'(i)) begin
                asm_wr[i*DATA_W +: DATA_W] = data_i;
            end
        end

        asm_d       = asm_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_bytes_d = out_bytes_q;
        out_last_d  = out_last_q;
        out_vld_d   = out_vld_q;

        if (drain_i) begin
            out_vld_d = 1'b0;
        end

        // asm is cleared whenever its contents move out, so unwritten slices are zero padding.
        if (complete) begin
            out_data_d  = asm_wr;
            out_bytes_d = BW'(N);
            out_last_d  = 1'b0;
            out_vld_d   = 1'b1;
            asm_d       = '0;
            cnt_d       = '0;
        end else if (acc) begin
            asm_d = asm_wr;
            cnt_d = cnt_q + CW'(1);
        end else if (fin_fire) begin
            out_data_d  = asm_q;
            out_bytes_d = BW'(cnt_q);
            out_last_d  = 1'b1;
            out_vld_d   = 1'b1;
            asm_d       = '0;
            cnt_d       = '0;
        end
    end

    // Lane state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            asm_q       <= '0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_bytes_q <= '0;
            out_last_q  <= 1'b0;
            out_vld_q   <= 1'b0;
        end else begin
            asm_q       <= asm_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_bytes_q <= out_bytes_d;
            out_last_q  <= out_last_d;
            out_vld_q   <= out_vld_d;
        end
    end

    assign out_data_o  = out_data_q;
    assign out_bytes_o = out_bytes_q;
    assign out_last_o  = out_last_q;
    assign out_vld_o   = out_vld_q;

endmodule

// File: rtl/ebpc_stream_packer.sv
// Packs the ZNZ and BPC byte streams into tagged OUT_W words on one round-robin bus.
// Latency: a completed word can be presented on the edge after its last byte is accepted.
// Backpressure: rdy_i low freezes the granted word; lanes stall once their out register is full.
module ebpc_stream_packer
    import ebpc_pkg::*;
#(
    parameter  int DATA_W = 8,
    parameter  int OUT_W  = 32,
    localparam int N      = OUT_W / DATA_W,
    localparam int BW     = $clog2(N) + 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [DATA_W-1:0] znz_data_i,
    input  logic              znz_vld_i,
    output logic              znz_rdy_o,
    input  logic [DATA_W-1:0] bpc_data_i,
    input  logic              bpc_vld_i,
    output logic              bpc_rdy_o,
    input  logic              flush_vld_i,
    output logic              flush_rdy_o,
    output logic [OUT_W-1:0]  data_o,
    output logic              src_o,
    output logic [BW-1:0]     bytes_o,
    output logic              last_o,
    output logic              vld_o,
    input  logic              rdy_i
);

    if (OUT_W % DATA_W != 0) begin : g_bad_width
        $error("OUT_W must be a multiple of DATA_W");
    end

    flush_state_e     state_q, state_d;
    logic [1:0]       fin_q, fin_d;
    logic [1:0]       fin_req, fin_done, drain, lane_vld;
    logic             accept_en;
    logic             ptr_q, ptr_d, gnt_q, lock_q, lock_d;
    logic             arb_gnt, gnt, out_hs;
    logic [OUT_W-1:0] lane_data  [2];
    logic [BW-1:0]    lane_bytes [2];
    logic [1:0]       lane_last;

    assign accept_en = (state_q == IDLE);
    assign fin_req   = (state_q == FLUSH) ? ~fin_q : 2'b00;

    ebpc_pack_lane #(.DATA_W(DATA_W), .OUT_W(OUT_W)) u_znz (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .data_i      (znz_data_i),
        .vld_i       (znz_vld_i),
        .rdy_o       (znz_rdy_o),
        .accept_en_i (accept_en),
        .fin_i       (fin_req[SRC_ZNZ]),
        .fin_done_o  (fin_done[SRC_ZNZ]),
        .drain_i     (drain[SRC_ZNZ]),
        .out_data_o  (lane_data[SRC_ZNZ]),
        .out_bytes_o (lane_bytes[SRC_ZNZ]),
        .out_last_o  (lane_last[SRC_ZNZ]),
        .out_vld_o   (lane_vld[SRC_ZNZ])
    );

    ebpc_pack_lane #(.DATA_W(DATA_W), .OUT_W(OUT_W)) u_bpc (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .data_i      (bpc_data_i),
        .vld_i       (bpc_vld_i),
        .rdy_o       (bpc_rdy_o),
        .accept_en_i (accept_en),
        .fin_i       (fin_req[SRC_BPC]),
        .fin_done_o  (fin_done[SRC_BPC]),
        .drain_i     (drain[SRC_BPC]),
        .out_data_o  (lane_data[SRC_BPC]),
        .out_bytes_o (lane_bytes[SRC_BPC]),
        .out_last_o  (lane_last[SRC_BPC]),
        .out_vld_o   (lane_vld[SRC_BPC])
    );

    assign vld_o = |lane_vld;

    // Round-robin grant; a stalled grant is locked so the presented word cannot change under backpressure.
    always_comb begin
        arb_gnt = ptr_q;
        if (lane_vld == 2'b01) begin
            arb_gnt = SRC_ZNZ;
        end else if (lane_vld == 2'b10) begin
            arb_gnt = SRC_BPC;
        end
        gnt         = lock_q ? gnt_q : arb_gnt;
        out_hs      = vld_o && rdy_i;
        drain       = 2'b00;
        drain[gnt]  = out_hs;
        ptr_d       = out_hs ? ~gnt : ptr_q;
        lock_d      = vld_o && !rdy_i;
    end

    // Output fields come straight from the granted lane's out register.
    always_comb begin
        data_o  = lane_data[gnt];
        bytes_o = lane_bytes[gnt];
        last_o  = lane_last[gnt];
        src_o   = gnt;
    end

    // Flush FSM: finalise each lane exactly once, then wait for both out registers to empty.
    always_comb begin
        state_d     = state_q;
        fin_d       = fin_q;
        flush_rdy_o = 1'b0;
        case (state_q)
            IDLE: begin
                flush_rdy_o = 1'b1;
                if (flush_vld_i) begin
                    state_d = FLUSH;
                    fin_d   = 2'b00;
                end
            end
            FLUSH: begin
                fin_d = fin_q | fin_done;
                if (fin_d == 2'b11) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (lane_vld == 2'b00) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Arbiter and FSM registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            fin_q   <= 2'b00;
            ptr_q   <= SRC_ZNZ;
            gnt_q   <= SRC_ZNZ;
            lock_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            fin_q   <= fin_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt;
            lock_q  <= lock_d;
        end
    end

endmodule

// File: tb/tb_ebpc_stream_packer.sv
// Self-checking bench for ebpc_stream_packer: directed scenarios plus randomized traffic.
// Latency: the scoreboard is order-based per lane, so it tolerates any legal output timing.
// Backpressure: rdy_i is toggled to exercise stalls; held outputs are checked for stability.
module tb_ebpc_stream_packer;

    localparam int DATA_W = 8;
    localparam int OUT_W  = 32;
    localparam int N      = OUT_W / DATA_W;
    localparam int BW     = $clog2(N) + 1;
    localparam int LIM    = 400;

    typedef logic [OUT_W+BW:0] ent_t;   // {last, bytes, data}

    logic              clk_i       = 1'b0;
    logic              rst_ni      = 1'b1;
    logic [DATA_W-1:0] znz_data_i  = '0;
    logic              znz_vld_i   = 1'b0;
    logic              znz_rdy_o;
    logic [DATA_W-1:0] bpc_data_i  = '0;
    logic              bpc_vld_i   = 1'b0;
    logic              bpc_rdy_o;
    logic              flush_vld_i = 1'b0;
    logic              flush_rdy_o;
    logic [OUT_W-1:0]  data_o;
    logic              src_o;
    logic [BW-1:0]     bytes_o;
    logic              last_o;
    logic              vld_o;
    logic              rdy_i       = 1'b1;

    always #5 clk_i = ~clk_i;

    ebpc_stream_packer #(.DATA_W(DATA_W), .OUT_W(OUT_W)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .znz_data_i  (znz_data_i),
        .znz_vld_i   (znz_vld_i),
        .znz_rdy_o   (znz_rdy_o),
        .bpc_data_i  (bpc_data_i),
        .bpc_vld_i   (bpc_vld_i),
        .bpc_rdy_o   (bpc_rdy_o),
        .flush_vld_i (flush_vld_i),
        .flush_rdy_o (flush_rdy_o),
        .data_o      (data_o),
        .src_o       (src_o),
        .bytes_o     (bytes_o),
        .last_o      (last_o),
        .vld_o       (vld_o),
        .rdy_i       (rdy_i)
    );

    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    logic [7:0] lst0[$];
    logic [7:0] lst1[$];
    ent_t exp0[$];
    ent_t exp1[$];
    logic src_log[$];
    int   cyc_log[$];
    bit   hold_pend = 1'b0;
    logic [OUT_W+BW+1:0] hold_val;

    task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    endtask

    // Reference model: bytes of the open frame per lane, packed little-endian when a word fills or a flush lands.
    function automatic logic [OUT_W-1:0] word0();
        logic [OUT_W-1:0] w = '0;
        foreach (lst0[i]) w[i*DATA_W +: DATA_W] = lst0[i];
        return w;
    endfunction

    function automatic logic [OUT_W-1:0] word1();
        logic [OUT_W-1:0] w = '0;
        foreach (lst1[i]) w[i*DATA_W +: DATA_W] = lst1[i];
        return w;
    endfunction

    task automatic model_byte(input logic lane, input logic [7:0] b);
        if (lane == 1'b0) begin
            lst0.push_back(b);
            if (lst0.size() == N) begin
                exp0.push_back({1'b0, BW'(N), word0()});
                lst0.delete();
            end
        end else begin
            lst1.push_back(b);
            if (lst1.size() == N) begin
                exp1.push_back({1'b0, BW'(N), word1()});
                lst1.delete();
            end
        end
    endtask

    task automatic model_flush();
        exp0.push_back({1'b1, BW'(lst0.size()), word0()});
        exp1.push_back({1'b1, BW'(lst1.size()), word1()});
        lst0.delete();
        lst1.delete();
    endtask

    // Monitor: on the falling edge, check outputs, then record the handshakes the next rising edge commits.
    always @(negedge clk_i) begin
        ent_t got, e;
        cyc++;
        if (!rst_ni) begin
            lst0.delete(); lst1.delete(); exp0.delete(); exp1.delete();
            hold_pend = 1'b0;
        end else begin
            if (hold_pend)
                check(vld_o && ({data_o, src_o, bytes_o, last_o} === hold_val), "stall hold",
                      64'({data_o, src_o, bytes_o, last_o}), 64'(hold_val));
            hold_pend = vld_o && !rdy_i;
            hold_val  = {data_o, src_o, bytes_o, last_o};
            if (vld_o && rdy_i) begin
                got = {last_o, bytes_o, data_o};
                src_log.push_back(src_o);
                cyc_log.push_back(cyc);
                if (src_o == 1'b0) begin
                    check(exp0.size() != 0, "znz word expected", 64'(got), 64'(0));
                    if (exp0.size() != 0) begin
                        e = exp0.pop_front();
                        check(got === e, "znz word", 64'(got), 64'(e));
                    end
                end else begin
                    check(exp1.size() != 0, "bpc word expected", 64'(got), 64'(0));
                    if (exp1.size() != 0) begin
                        e = exp1.pop_front();
                        check(got === e, "bpc word", 64'(got), 64'(e));
                    end
                end
            end
            if (znz_vld_i && znz_rdy_o) model_byte(1'b0, znz_data_i);
            if (bpc_vld_i && bpc_rdy_o) model_byte(1'b1, bpc_data_i);
            if (flush_vld_i && flush_rdy_o) model_flush();
        end
    end

    task automatic do_reset(input string name);
        rst_ni = 1'b0;
        #1;
        check({vld_o, data_o, src_o, bytes_o, last_o, znz_rdy_o, bpc_rdy_o, flush_rdy_o} === {1'b0, 32'h0, 1'b0, 3'd0, 1'b0, 3'b111},
              name, 64'({vld_o, data_o, src_o, bytes_o, last_o, znz_rdy_o, bpc_rdy_o, flush_rdy_o}), 64'(7));
        @(posedge clk_i); @(posedge clk_i); #1;
        rst_ni = 1'b1;
    endtask

    task automatic push_znz(input logic [7:0] b);
        int t = 0;
        znz_data_i = b; znz_vld_i = 1'b1;
        @(negedge clk_i);
        while (!znz_rdy_o && t < LIM) begin @(negedge clk_i); t++; end
        check(t < LIM, "znz accept timeout", 64'(t), 64'(LIM));
        @(posedge clk_i); #1;
        znz_vld_i = 1'b0;
    endtask

    task automatic push_bpc(input logic [7:0] b);
        int t = 0;
        bpc_data_i = b; bpc_vld_i = 1'b1;
        @(negedge clk_i);
        while (!bpc_rdy_o && t < LIM) begin @(negedge clk_i); t++; end
        check(t < LIM, "bpc accept timeout", 64'(t), 64'(LIM));
        @(posedge clk_i); #1;
        bpc_vld_i = 1'b0;
    endtask

    task automatic do_flush();
        int t = 0;
        flush_vld_i = 1'b1;
        @(negedge clk_i);
        while (!flush_rdy_o && t < LIM) begin @(negedge clk_i); t++; end
        check(t < LIM, "flush accept timeout", 64'(t), 64'(LIM));
        @(posedge clk_i); #1;
        flush_vld_i = 1'b0;
    endtask

    task automatic wait_empty(input string name);
        int t = 0;
        while (!(exp0.size() == 0 && exp1.size() == 0 && !vld_o && flush_rdy_o) && t < LIM) begin
            @(posedge clk_i); #1; t++;
        end
        check(t < LIM, name, 64'(t), 64'(LIM));
    endtask

    task automatic dual_word(input logic [7:0] base);
        for (int i = 0; i < N; i++) begin
            znz_data_i = base + 8'(i); bpc_data_i = base + 8'h40 + 8'(i);
            znz_vld_i = 1'b1; bpc_vld_i = 1'b1;
            @(negedge clk_i);
            check(znz_rdy_o && bpc_rdy_o, "dual accept", 64'({znz_rdy_o, bpc_rdy_o}), 64'(3));
            @(posedge clk_i); #1;
        end
        znz_vld_i = 1'b0; bpc_vld_i = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  idx;
        bit  a, za, ba, fa;
        #2;
        do_reset("reset state");

        // Plain ZNZ packing, no backpressure.
        src_log.delete();
        for (int i = 1; i <= 8; i++) push_znz(8'(i));
        wait_empty("znz pack drain");
        check(src_log.size() == 2, "znz pack count", 64'(src_log.size()), 64'(2));

        // Both lanes complete together: ZNZ then BPC on consecutive cycles, twice.
        do_reset("reset before dual");
        src_log.delete(); cyc_log.delete();
        dual_word(8'h20);
        wait_empty("dual drain 1");
        dual_word(8'h60);
        wait_empty("dual drain 2");
        check(src_log.size() == 4, "dual count", 64'(src_log.size()), 64'(4));
        if (src_log.size() == 4) begin
            check({src_log[0], src_log[1], src_log[2], src_log[3]} == 4'b0101, "round robin order",
                  64'({src_log[0], src_log[1], src_log[2], src_log[3]}), 64'(4'b0101));
            check(cyc_log[1] - cyc_log[0] == 1, "bpc next cycle", 64'(cyc_log[1] - cyc_log[0]), 64'(1));
            check(cyc_log[3] - cyc_log[2] == 1, "bpc next cycle 2", 64'(cyc_log[3] - cyc_log[2]), 64'(1));
        end

        // Partial BPC frame with ZNZ empty: ZNZ marker then BPC tail.
        do_reset("reset before flush");
        src_log.delete();
        push_bpc(8'hAA); push_bpc(8'hBB); push_bpc(8'hCC);
        do_flush();
        wait_empty("flush drain");
        check(src_log.size() == 2, "flush count", 64'(src_log.size()), 64'(2));
        if (src_log.size() == 2)
            check({src_log[0], src_log[1]} == 2'b01, "flush order", 64'({src_log[0], src_log[1]}), 64'(1));
        check({flush_rdy_o, znz_rdy_o, bpc_rdy_o} == 3'b111, "idle after drain",
              64'({flush_rdy_o, znz_rdy_o, bpc_rdy_o}), 64'(7));

        // Output stall: one full word buffered plus three bytes, then the lane blocks.
        rdy_i = 1'b0; idx = 0;
        znz_vld_i = 1'b1; znz_data_i = 8'h10;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk_i); a = znz_rdy_o;
            @(posedge clk_i); #1;
            if (a) begin idx++; znz_data_i = 8'h10 + 8'(idx); end
        end
        check(idx == 7, "stall accepted bytes", 64'(idx), 64'(7));
        check(znz_rdy_o == 1'b0, "stall znz rdy", 64'(znz_rdy_o), 64'(0));
        rdy_i = 1'b1;
        for (int c = 0; c < LIM && idx < 12; c++) begin
            @(negedge clk_i); a = znz_rdy_o;
            @(posedge clk_i); #1;
            if (a) begin idx++; znz_data_i = 8'h10 + 8'(idx); end
        end
        znz_vld_i = 1'b0;
        check(idx == 12, "stall total bytes", 64'(idx), 64'(12));
        wait_empty("stall drain");

        // Flush in the same cycle as the word-completing ZNZ byte.
        push_bpc(8'h5A);
        push_znz(8'hC1); push_znz(8'hC2); push_znz(8'hC3);
        znz_data_i = 8'hC4; znz_vld_i = 1'b1; flush_vld_i = 1'b1;
        @(negedge clk_i);
        check(znz_rdy_o && flush_rdy_o, "byte and flush together", 64'({znz_rdy_o, flush_rdy_o}), 64'(3));
        @(posedge clk_i); #1;
        znz_vld_i = 1'b0; flush_vld_i = 1'b0;
        wait_empty("same-cycle flush drain");

        // Reset with two bytes buffered; the next word must start clean.
        push_znz(8'hE1); push_znz(8'hE2);
        do_reset("reset mid-frame");
        src_log.delete();
        push_znz(8'hA1); push_znz(8'hA2); push_znz(8'hA3); push_znz(8'hA4);
        wait_empty("post-reset drain");
        check(src_log.size() == 1, "post-reset count", 64'(src_log.size()), 64'(1));

        // Randomized traffic with random backpressure and occasional flushes.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk_i);
            za = znz_vld_i && znz_rdy_o;
            ba = bpc_vld_i && bpc_rdy_o;
            fa = flush_vld_i && flush_rdy_o;
            @(posedge clk_i); #1;
            if (!znz_vld_i || za) begin znz_vld_i = ($urandom_range(0, 3) != 0); znz_data_i = 8'($urandom); end
            if (!bpc_vld_i || ba) begin bpc_vld_i = ($urandom_range(0, 3) != 0); bpc_data_i = 8'($urandom); end
            if (!flush_vld_i || fa) flush_vld_i = ($urandom_range(0, 40) == 0);
            rdy_i = ($urandom_range(0, 3) != 0);
        end
        znz_vld_i = 1'b0; bpc_vld_i = 1'b0; flush_vld_i = 1'b0; rdy_i = 1'b1;
        @(posedge clk_i); #1;
        do_flush();
        wait_empty("random drain");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ebpc_stream_packer.md
Name: ebpc_stream_packer

Overview:
- Sits directly downstream of ebpc_encoder and consumes its two byte streams, ZNZ (zero/non-zero) and BPC (bit-plane).
- Packs each stream independently into OUT_W-bit words, little-endian: the first byte lands in the LSBs.
- Merges both streams onto one tagged output bus through a round-robin arbiter.
- A flush handshake closes a frame: it emits each lane's partial word (or an empty marker) with last_o set, so the decoder side sees a per-lane frame boundary.

Parameters:
- DATA_W, 8: byte width of the encoder output streams.
- OUT_W, 32: packed word width; must be a multiple of DATA_W (elaboration assert).
- N (derived), OUT_W/DATA_W: bytes per word.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- znz_data_i  in  DATA_W  ZNZ byte.
- znz_vld_i  in  1  ZNZ valid.
- znz_rdy_o  out  1  ZNZ ready.
- bpc_data_i  in  DATA_W  BPC byte.
- bpc_vld_i  in  1  BPC valid.
- bpc_rdy_o  out  1  BPC ready.
- flush_vld_i  in  1  end-of-frame request.
- flush_rdy_o  out  1  flush accepted.
- data_o  out  OUT_W  packed word; unused bytes are zero.
- src_o  out  1  source lane: 0 = ZNZ, 1 = BPC.
- bytes_o  out  $clog2(N)+1  number of valid bytes in data_o, 0..N.
- last_o  out  1  final word of this lane for the frame.
- vld_o  out  1  output valid.
- rdy_i  in  1  output ready.

Behaviour:
- Reset values (asynchronous on rst_ni low): all registers cleared. Outputs: vld_o=0, data_o=0, src_o=0, bytes_o=0, last_o=0. Ready outputs: lane rdy_o=1, flush_rdy_o=1. Arbiter pointer favours ZNZ. FSM in IDLE.
- Reset mid-frame: any partial word and pending output are discarded; no output is produced for them.
- Lane state (per lane): assembly register asm, byte counter cnt (0..N-1), output register out with out_vld, out_bytes, out_last.
- Byte handshake: a byte is transferred when vld && rdy. It is written to asm slice cnt and cnt increments.
- Word completion: when a byte is accepted at cnt==N-1, the full word moves to out (bytes=N, last=0) at the next edge and cnt wraps to 0. The next byte may be accepted in the following cycle.
- Lane ready: lane rdy_o = (state==IDLE) && ((cnt != N-1) || !out_vld || out_drain), where out_drain means this lane is granted and rdy_i=1. Combinational from rdy_i is permitted.
- Latency: the Nth byte accepted at edge k gives vld_o no earlier than edge k+1.
- Arbiter: vld_o = OR of the lanes' out_vld; data_o, src_o, bytes_o and last_o are muxed from the granted lane.
  - While vld_o && !rdy_i, the grant and all output fields are held stable.
  - After each output handshake the pointer moves to the other lane.
  - A lone valid lane is granted immediately.
- Flush FSM, IDLE -> FLUSH -> DRAIN -> IDLE:
  - IDLE: flush_rdy_o=1. On flush_vld_i the FSM goes to FLUSH. Lane bytes accepted in the same cycle belong to the frame being flushed.
  - FLUSH: lane rdy_o=0 and flush_rdy_o=0. For each lane that is not yet finalised and whose out register is free (or draining this cycle), move asm to out with bytes=cnt, last=1, zero padding, and clear cnt. cnt==0 produces an empty marker: data 0, bytes 0, last 1. Exactly one last word per lane per flush. When both lanes are finalised, go to DRAIN.
  - DRAIN: wait until both out_vld are 0, then go to IDLE.
- Ordering: each lane's words leave in acceptance order, and its last word is always its final word of the frame. Interleaving between lanes is arbitrary but follows the round-robin rule.
- Simultaneous events: a full-word completion and a flush in the same cycle are handled by the full word moving first; the flush in FLUSH then emits an empty marker, or the remaining bytes if any.

Decomposition:
- Package ebpc_pkg holds:
  - lane id constants SRC_ZNZ=0, SRC_BPC=1;
  - the flush FSM state enum (IDLE, FLUSH, DRAIN).
- Sub-module ebpc_pack_lane (asm, cnt, out register, finalise input) is instantiated twice.
- The arbiter and FSM live in the top module.

Test Plan:
- ZNZ bytes 01..08, rdy_i=1, no BPC -> words 0x04030201, then 0x08070605; src=0, bytes=4, last=0.
- 4 ZNZ bytes and 4 BPC bytes completing in the same cycle after reset -> ZNZ word first, then BPC word on the next cycle; then the pointer favours ZNZ again.
- BPC bytes AA BB CC, then flush, no ZNZ -> ZNZ marker (data 0, bytes 0, last 1, src 0), then 0x00CCBBAA (bytes 3, last 1, src 1); flush_rdy_o=1 again after DRAIN.
- rdy_i=0 while 12 ZNZ bytes are offered -> exactly 7 bytes accepted and znz_rdy_o=0 at cnt==3; data_o stable for the whole stall; after rdy_i=1, words in order with no loss.
- Flush asserted in the same cycle as the 4th ZNZ byte -> full word (bytes 4, last 0), then ZNZ marker (bytes 0, last 1), plus the BPC last word.
- rst_ni low mid-frame with 2 bytes buffered -> vld_o=0 and lane rdy=1 immediately; after release, new bytes pack from slice 0 with no stale data.
